// File: rtl/flash_pkg.sv
// Shared types and constants for the flash arbiter/sequencer.
package flash_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin grant; pointer names the port favoured on a tie.
module flash_rr_arb
  import flash_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic       gnt,
  output logic       valid
);

  // Sole requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt   = P0;
    valid = |req;
    if (req == 2'b11) begin
      gnt = pointer;
    end else if (req[1]) begin
      gnt = P1;
    end else begin
      gnt = P0;
    end
  end

endmodule

// File: rtl/flash_arb_ctrl.sv
// Shares one NOR flash pad set between two Wishbone masters with
// round-robin arbitration and programmable read wait states.
module flash_arb_ctrl
  import flash_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int RST_HOLD    = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  input  logic              m0_we_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  input  logic              m1_we_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic [ADDR_W-1:0] flash_addr_,
  input  logic [DATA_W-1:0] flash_data_,
  output logic              flash_ce_n_,
  output logic              flash_oe_n_,
  output logic              flash_we_n_,
  output logic              flash_rst_n_
);

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] data, data_nx;
  logic              ce_n, ce_n_nx;
  logic              oe_n, oe_n_nx;
  logic              rst_n, rst_n_nx;
  logic              ack, ack_nx;
  logic              ptr, ptr_nx;
  logic              gnt, gnt_nx;

  logic [1:0]        req;
  logic              arb_gnt;
  logic              arb_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_adr;

  assign req     = {m1_stb_i & m1_cyc_i, m0_stb_i & m0_cyc_i};
  assign sel_we  = (arb_gnt == P1) ? m1_we_i  : m0_we_i;
  assign sel_adr = (arb_gnt == P1) ? m1_adr_i : m0_adr_i;

  flash_rr_arb u_arb (
    .req     (req),
    .pointer (ptr),
    .gnt     (arb_gnt),
    .valid   (arb_valid)
  );

  // State and pad registers; reset forces the pads inactive immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_RST;
      cnt   <= 8'(RST_HOLD);
      addr  <= '0;
      data  <= '0;
      ce_n  <= 1'b1;
      oe_n  <= 1'b1;
      rst_n <= 1'b0;
      ack   <= 1'b0;
      ptr   <= P0;
      gnt   <= P0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      data  <= data_nx;
      ce_n  <= ce_n_nx;
      oe_n  <= oe_n_nx;
      rst_n <= rst_n_nx;
      ack   <= ack_nx;
      ptr   <= ptr_nx;
      gnt   <= gnt_nx;
    end
  end

  // Next-state logic; ack is raised on entry to ACK so it is high for that one cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    data_nx  = data;
    ce_n_nx  = ce_n;
    oe_n_nx  = oe_n;
    rst_n_nx = rst_n;
    ack_nx   = 1'b0;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    case (state)
      S_RST: begin
        if (cnt <= 8'd1) begin
          cnt_nx   = 8'd0;
          rst_n_nx = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_IDLE: begin
        if (arb_valid) begin
          gnt_nx = arb_gnt;
          if (sel_we) begin
            ack_nx   = 1'b1;
            state_nx = S_ACK;
          end else begin
            addr_nx  = sel_adr;
            ce_n_nx  = 1'b0;
            oe_n_nx  = 1'b0;
            cnt_nx   = 8'(WAIT_CYCLES);
            state_nx = S_ACCESS;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          data_nx  = flash_data_;
          ce_n_nx  = 1'b1;
          oe_n_nx  = 1'b1;
          ack_nx   = 1'b1;
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        ptr_nx   = ~gnt;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_RST;
      end
    endcase
  end

  // An abandoned master (stb/cyc dropped) never sees the ack of its pad cycle.
  assign m0_ack_o     = ack & (gnt == P0) & req[0];
  assign m1_ack_o     = ack & (gnt == P1) & req[1];
  assign m0_dat_o     = data;
  assign m1_dat_o     = data;
  assign flash_addr_  = addr;
  assign flash_ce_n_  = ce_n;
  assign flash_oe_n_  = oe_n;
  assign flash_we_n_  = 1'b1;
  assign flash_rst_n_ = rst_n;

endmodule

// File: tb/tb_flash_arb_ctrl.sv
// Directed plus randomized bench for flash_arb_ctrl with a transaction-level reference model.
module tb_flash_arb_ctrl;

  localparam int WAITC = 3;
  localparam int HOLD  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] m0_adr, m1_adr;
  logic        m0_stb, m0_cyc, m0_we, m1_stb, m1_cyc, m1_we;
  logic [15:0] m0_dat, m1_dat;
  logic        m0_ack, m1_ack;
  logic [20:0] flash_addr;
  logic [15:0] flash_data;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n;

  int          total = 0;
  int          bad = 0;
  logic        ptr_m;
  logic [15:0] last_data;

  flash_arb_ctrl #(.WAIT_CYCLES(WAITC), .RST_HOLD(HOLD)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .m0_adr_i     (m0_adr),
    .m0_stb_i     (m0_stb),
    .m0_cyc_i     (m0_cyc),
    .m0_we_i      (m0_we),
    .m0_dat_o     (m0_dat),
    .m0_ack_o     (m0_ack),
    .m1_adr_i     (m1_adr),
    .m1_stb_i     (m1_stb),
    .m1_cyc_i     (m1_cyc),
    .m1_we_i      (m1_we),
    .m1_dat_o     (m1_dat),
    .m1_ack_o     (m1_ack),
    .flash_addr_  (flash_addr),
    .flash_data_  (flash_data),
    .flash_ce_n_  (flash_ce_n),
    .flash_oe_n_  (flash_oe_n),
    .flash_we_n_  (flash_we_n),
    .flash_rst_n_ (flash_rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] flash_word(input logic [20:0] a);
    case (a)
      21'h00010: flash_word = 16'h1111;
      21'h00020: flash_word = 16'h2222;
      21'h00100: flash_word = 16'hBEEF;
      default:   flash_word = a[15:0] ^ {a[20:16], 11'h2A5};
    endcase
  endfunction

  assign flash_data = flash_word(flash_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input bit on, input bit we, input logic [20:0] adr);
    if (port == 0) begin
      m0_stb = on; m0_cyc = on; m0_we = we; m0_adr = adr;
    end else begin
      m1_stb = on; m1_cyc = on; m1_we = we; m1_adr = adr;
    end
  endtask

  // Wait for the given port's ack, checking latency, pad behaviour and returned data.
  task automatic expect_ack(input int port, input int lat, input bit rd, input logic [20:0] adr);
    int          t;
    int          ce_low;
    bit          seen;
    logic [15:0] exp_d;
    t = 0; ce_low = 0; seen = 1'b0;
    exp_d = rd ? flash_word(adr) : last_data;
    while (!seen && t < lat + 8) begin
      tick();
      t++;
      chk("oe_follows_ce", 32'(flash_oe_n), 32'(flash_ce_n));
      chk("we_n_high", 32'(flash_we_n), 32'd1);
      if (flash_ce_n == 1'b0) begin
        ce_low++;
        chk("addr_stable", 32'(flash_addr), 32'(adr));
      end
      chk("other_no_ack", 32'(port == 0 ? m1_ack : m0_ack), 32'd0);
      if ((port == 0 ? m0_ack : m1_ack) == 1'b1) seen = 1'b1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_latency", 32'(t), 32'(lat));
    chk("ce_low_cycles", 32'(ce_low), rd ? 32'(WAITC + 1) : 32'd0);
    chk("dat_port", 32'(port == 0 ? m0_dat : m1_dat), 32'(exp_d));
    chk("dat_shared", 32'(m0_dat), 32'(m1_dat));
    last_data = exp_d;
    ptr_m = (port == 0) ? 1'b1 : 1'b0;
  endtask

  initial begin
    logic [20:0] a0, a1, ar;
    bit          r0, r1, w0, w1;
    int          win, oth;
    bit          w_rd, o_rd;
    logic [20:0] w_adr, o_adr;

    // Reset with a port 0 read already pending.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 21'h00100);
    set_req(1, 1'b0, 1'b0, 21'h0);
    ptr_m = 1'b0; last_data = 16'h0;
    #2;
    chk("rst_ce_n", 32'(flash_ce_n), 32'd1);
    chk("rst_oe_n", 32'(flash_oe_n), 32'd1);
    chk("rst_rst_n", 32'(flash_rst_n), 32'd0);
    chk("rst_addr", 32'(flash_addr), 32'd0);
    chk("rst_dat", 32'(m0_dat), 32'd0);
    chk("rst_ack0", 32'(m0_ack), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      chk("hold_rst_n", 32'(flash_rst_n), (i < HOLD) ? 32'd0 : 32'd1);
      chk("hold_ce_n", 32'(flash_ce_n), 32'd1);
    end
    expect_ack(0, WAITC + 2, 1'b1, 21'h00100);
    set_req(0, 1'b0, 1'b0, 21'h0);

    // Write: ack next cycle, pads untouched, data register unchanged.
    tick(); tick();
    set_req(0, 1'b1, 1'b1, 21'h00777);
    expect_ack(0, 1, 1'b0, 21'h00777);
    set_req(0, 1'b0, 1'b0, 21'h0);

    // Randomized rounds: one or both ports, mixed reads and writes.
    for (int n = 0; n < 30; n++) begin
      tick(); tick();
      r0 = 1'b0; r1 = 1'b0;
      case ($urandom_range(1, 3))
        1: r0 = 1'b1;
        2: r1 = 1'b1;
        default: begin r0 = 1'b1; r1 = 1'b1; end
      endcase
      w0 = ($urandom_range(0, 3) == 0);
      w1 = ($urandom_range(0, 3) == 0);
      a0 = 21'($urandom);
      a1 = 21'($urandom);
      set_req(0, r0, w0, a0);
      set_req(1, r1, w1, a1);
      if (r0 && r1) win = (ptr_m == 1'b1) ? 1 : 0;
      else win = r0 ? 0 : 1;
      oth = 1 - win;
      w_rd = (win == 0) ? !w0 : !w1;
      w_adr = (win == 0) ? a0 : a1;
      o_rd = (oth == 0) ? !w0 : !w1;
      o_adr = (oth == 0) ? a0 : a1;
      expect_ack(win, w_rd ? WAITC + 2 : 1, w_rd, w_adr);
      set_req(win, 1'b0, 1'b0, 21'h0);
      if (r0 && r1) begin
        expect_ack(oth, 1 + (o_rd ? WAITC + 2 : 1), o_rd, o_adr);
        set_req(oth, 1'b0, 1'b0, 21'h0);
      end
    end

    // Abort: m1 drops its strobe mid-access; no ack, then m0 is served normally.
    tick(); tick();
    ar = 21'h0ABCD;
    set_req(1, 1'b1, 1'b0, ar);
    tick(); tick(); tick();
    chk("abort_ce_low", 32'(flash_ce_n), 32'd0);
    set_req(1, 1'b0, 1'b0, 21'h0);
    for (int i = 0; i < WAITC + 3; i++) begin
      tick();
      chk("abort_no_ack1", 32'(m1_ack), 32'd0);
      chk("abort_no_ack0", 32'(m0_ack), 32'd0);
    end
    chk("abort_ce_done", 32'(flash_ce_n), 32'd1);
    last_data = flash_word(ar);
    ptr_m = 1'b0;
    a0 = 21'($urandom);
    set_req(0, 1'b1, 1'b0, a0);
    expect_ack(0, WAITC + 2, 1'b1, a0);
    set_req(0, 1'b0, 1'b0, 21'h0);

    // Reset during an access: pads released with no clock edge and no ack.
    tick(); tick();
    set_req(0, 1'b1, 1'b0, 21'h01234);
    tick(); tick();
    chk("mid_ce_low", 32'(flash_ce_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_ce_n", 32'(flash_ce_n), 32'd1);
    chk("mid_oe_n", 32'(flash_oe_n), 32'd1);
    chk("mid_rst_n", 32'(flash_rst_n), 32'd0);
    chk("mid_ack", 32'(m0_ack), 32'd0);
    chk("mid_dat", 32'(m0_dat), 32'd0);
    set_req(0, 1'b1, 1'b0, 21'h00010);
    set_req(1, 1'b1, 1'b0, 21'h00020);
    tick();
    chk("mid_ack_held", 32'(m0_ack | m1_ack), 32'd0);
    tick();
    rst = 1'b0;
    last_data = 16'h0;
    ptr_m = 1'b0;

    // Continuous contention from reset: grants alternate 0,1,0,1.
    expect_ack(0, HOLD + WAITC + 2, 1'b1, 21'h00010);
    expect_ack(1, WAITC + 3, 1'b1, 21'h00020);
    expect_ack(0, WAITC + 3, 1'b1, 21'h00010);
    expect_ack(1, WAITC + 3, 1'b1, 21'h00020);
    set_req(0, 1'b0, 1'b0, 21'h0);
    set_req(1, 1'b0, 1'b0, 21'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
